regfile_param: RTL and testbench

Parametrised multi-entry register file with one synchronous write port and two combinational read ports. Adds per-entry valid tracking, a synchronous clear, sticky out-of-range write error reporting and a saturating write counter. Sits in the datapath as operand storage; the read ports feed the execute stage and the write port is driven from writeback.

---
 rtl/regfile_param.sv | 102 ++++++++++
 tb/tb_regfile_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: 1 sync write, 2 comb reads, valid bits, error flag.
// Define REGFILE_BYPASS_EN to forward accepted write data to matching read ports.
module regfile_param #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned DEPTH  = 9,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              wrEN,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              clr,
  input  logic              err_clr,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              rd1_valid,
  output logic              rd2_valid,
  output logic              addr_err,
  output logic [7:0]        wr_cnt
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  logic wa_ok;
  logic rs1_ok;
  logic rs2_ok;
  logic wr_ok;
  logic wr_bad;

  assign wa_ok  = 32'(WA) < DEPTH;
  assign rs1_ok = 32'(RS1) < DEPTH;
  assign rs2_ok = 32'(RS2) < DEPTH;
  assign wr_ok  = wrEN & ~clr & wa_ok;
  assign wr_bad = wrEN & ~clr & ~wa_ok;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld    <= '0;
      wr_cnt <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      vld    <= '0;
      wr_cnt <= '0;
    end else if (wr_ok) begin
      mem[WA] <= WD;
      vld[WA] <= 1'b1;
      if (wr_cnt != 8'hFF) wr_cnt <= wr_cnt + 8'd1;
    end
  end

  // A set in the same cycle as err_clr wins.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else if (wr_bad) begin
      addr_err <= 1'b1;
    end else if (err_clr) begin
      addr_err <= 1'b0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp;
  assign byp = wr_ok & rst_n;
`endif

  always_comb begin
    RD1       = '0;
    rd1_valid = 1'b0;
    if (rs1_ok) begin
      RD1       = mem[RS1];
      rd1_valid = vld[RS1];
    end
`ifdef REGFILE_BYPASS_EN
    if (byp && RS1 == WA) begin
      RD1       = WD;
      rd1_valid = 1'b1;
    end
`endif
  end

  always_comb begin
    RD2       = '0;
    rd2_valid = 1'b0;
    if (rs2_ok) begin
      RD2       = mem[RS2];
      rd2_valid = vld[RS2];
    end
`ifdef REGFILE_BYPASS_EN
    if (byp && RS2 == WA) begin
      RD2       = WD;
      rd2_valid = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_regfile_param;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        wrEN;
  logic [3:0]  WA;
  logic [17:0] WD;
  logic        clr;
  logic        err_clr;
  logic [3:0]  RS1;
  logic [3:0]  RS2;
  logic [17:0] RD1;
  logic [17:0] RD2;
  logic        rd1_valid;
  logic        rd2_valid;
  logic        addr_err;
  logic [7:0]  wr_cnt;

  regfile_param #(
    .DATA_W(18),
    .DEPTH (9),
    .ADDR_W(4)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .wrEN     (wrEN),
    .WA       (WA),
    .WD       (WD),
    .clr      (clr),
    .err_clr  (err_clr),
    .RS1      (RS1),
    .RS2      (RS2),
    .RD1      (RD1),
    .RD2      (RD2),
    .rd1_valid(rd1_valid),
    .rd2_valid(rd2_valid),
    .addr_err (addr_err),
    .wr_cnt   (wr_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [17:0] rd1;
    logic [17:0] rd2;
    logic        v1;
    logic        v2;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", n, f, act, exp);
    end
  endtask

  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "RD1", 32'(RD1), 32'(e.rd1));
      cmp(e.name, "RD2", 32'(RD2), 32'(e.rd2));
      cmp(e.name, "rd1_valid", 32'(rd1_valid), 32'(e.v1));
      cmp(e.name, "rd2_valid", 32'(rd2_valid), 32'(e.v2));
      cmp(e.name, "addr_err", 32'(addr_err), 32'(e.err));
      cmp(e.name, "wr_cnt", 32'(wr_cnt), 32'(e.cnt));
    end
  end

  task automatic drive(input logic we, input logic [3:0] wa,
                       input logic [17:0] wd, input logic c,
                       input logic ec, input logic [3:0] r1,
                       input logic [3:0] r2);
    wrEN = we; WA = wa; WD = wd; clr = c; err_clr = ec;
    RS1 = r1; RS2 = r2;
  endtask

  task automatic expect_now(input string n, input logic [17:0] d1,
                            input logic [17:0] d2, input logic v1,
                            input logic v2, input logic err,
                            input logic [7:0] cnt);
    exp_t e;
    e.name = n; e.rd1 = d1; e.rd2 = d2; e.v1 = v1; e.v2 = v2;
    e.err = err; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 4'd0, 4'd8);
    tick();
    expect_now("reset", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    expect_now("idle", 0, 0, 0, 0, 0, 0);
    tick();

    // write 1, then read it back
    drive(1, 4'd1, 18'h2A02A, 0, 0, 4'd1, 4'd2);
    expect_now("wr1_pre", BYP ? 18'h2A02A : 18'h0, 0, BYP, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 4'd1, 4'd2);
    expect_now("wr1_post", 18'h2A02A, 0, 1, 0, 0, 1);
    tick();

    // same-cycle read of write address
    drive(1, 4'd2, 18'h00006, 0, 0, 4'd2, 4'd1);
    expect_now("byp_pre", BYP ? 18'h6 : 18'h0, 18'h2A02A, BYP, 1, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 4'd2, 4'd1);
    expect_now("byp_post", 18'h6, 18'h2A02A, 1, 1, 0, 2);
    tick();
    drive(0, 0, 0, 0, 0, 4'd1, 4'd1);
    expect_now("same_sel", 18'h2A02A, 18'h2A02A, 1, 1, 0, 2);
    tick();

    // out-of-range write
    drive(1, 4'd9, 18'h3FFFF, 0, 0, 4'd9, 4'd2);
    expect_now("oor_pre", 0, 18'h6, 0, 1, 0, 2);
    tick();
    drive(0, 0, 0, 0, 0, 4'd9, 4'd2);
    expect_now("oor_post", 0, 18'h6, 0, 1, 1, 2);
    tick();
    drive(0, 0, 0, 0, 0, 4'd1, 4'd0);
    expect_now("oor_noalias", 18'h2A02A, 0, 1, 0, 1, 2);
    tick();

    // err_clr with simultaneous out-of-range write: set wins
    drive(1, 4'd15, 18'h1, 0, 1, 4'd15, 4'd1);
    expect_now("eclr_set_pre", 0, 18'h2A02A, 0, 1, 1, 2);
    tick();
    drive(0, 0, 0, 0, 1, 4'd15, 4'd1);
    expect_now("eclr_set_post", 0, 18'h2A02A, 0, 1, 1, 2);
    tick();
    drive(0, 0, 0, 0, 0, 4'd15, 4'd1);
    expect_now("eclr_done", 0, 18'h2A02A, 0, 1, 0, 2);
    tick();

    // clr drops a concurrent out-of-range write without flagging it
    drive(1, 4'd12, 18'h5, 1, 0, 4'd1, 4'd2);
    expect_now("clr_oor_pre", 18'h2A02A, 18'h6, 1, 1, 0, 2);
    tick();
    drive(0, 0, 0, 0, 0, 4'd1, 4'd2);
    expect_now("clr_oor_post", 0, 0, 0, 0, 0, 0);
    tick();

    // fill every entry with 0x11
    for (int i = 0; i < 9; i++) begin
      drive(1, 4'(i), 18'h11, 0, 0, 4'd9, 4'd9);
      tick();
    end
    drive(1, 4'd10, 18'h0, 0, 0, 4'd3, 4'd8);
    expect_now("fill", 18'h11, 18'h11, 1, 1, 0, 9);
    tick();

    // clr with in-range write: clr wins, addr_err untouched, no bypass
    drive(1, 4'd3, 18'h55, 1, 0, 4'd3, 4'd8);
    expect_now("clr_pre", 18'h11, 18'h11, 1, 1, 1, 9);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 0, 0, 0, 4'(i), 4'(8 - i));
      expect_now($sformatf("clr_post%0d", i), 0, 0, 0, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 4'd9, 4'd9);
    tick();
    drive(0, 0, 0, 0, 0, 4'd9, 4'd9);

    // 300 accepted writes: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      drive(1, 4'(i % 9), 18'(i), 0, 0, 4'd9, 4'd9);
      expect_now($sformatf("sat%0d", i), 0, 0, 0, 0, 0,
                 8'((i > 255) ? 255 : i));
      tick();
    end
    drive(0, 0, 0, 0, 0, 4'd4, 4'd2);
    expect_now("sat_end", 18'd292, 18'd299, 1, 1, 0, 255);
    tick();

    // async reset pulse in the middle of a write
    drive(1, 4'd4, 18'h3ABCD, 0, 0, 4'd4, 4'd2);
    rst_n = 1'b0;
    #1;
    expect_now("rst_mid", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 4'd4, 4'd2);
    expect_now("rst_lost", 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 4'd4, 18'h123, 0, 0, 4'd4, 4'd2);
    tick();
    drive(0, 0, 0, 0, 0, 4'd4, 4'd2);
    expect_now("rst_after", 18'h123, 0, 1, 0, 0, 1);
    tick();

    repeat (2) @(posedge clock);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
